clock_time_counter: RTL
=======================

Name: clock_time_counter

Overview:
- Timekeeping core of the digital clock. Consumes the slow clock level produced by the clock divider as a tick source in the same `clk` domain.
- Counts seconds, minutes and hours in packed BCD for the display path.
- Accepts one-cycle set pulses from debounced buttons so the user can adjust the time.
- Sits between the clock divider and the 7-segment display multiplexer.

Parameters:
- TICKS_PER_SEC, 1, number of `tick_in` rising edges per one-second advance (range 1..255).
- PRESC_W, 8, width of the internal tick prescaler; must satisfy 2^PRESC_W > TICKS_PER_SEC.

Ports:
- clk  input  1  system clock; every register is clocked on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tick_in  input  1  slow-clock level from the divider, synchronous to `clk`; each 0->1 transition is one tick.
- run  input  1  1 = time advances on ticks; 0 = time held, set pulses still honoured.
- set_min  input  1  one-cycle pulse: increment minutes.
- set_hour  input  1  one-cycle pulse: increment hours.
- sec_bcd  output  8  seconds, packed BCD {tens,ones}, range 00..59.
- min_bcd  output  8  minutes, packed BCD, range 00..59.
- hour_bcd  output  8  hours, packed BCD, range 00..23 (see Optional Feature).
- sec_pulse  output  1  registered one-cycle strobe, high in the cycle after each second advance.

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`; the polarity and synchronicity are fixed.
- Reset values:
  - sec_bcd, min_bcd, hour_bcd = 8'h00.
  - sec_pulse = 0.
  - Prescaler = 0.
  - tick_q = 1, so a `tick_in` that is already high at reset release is not counted.
- Edge detect:
  - tick_q <= tick_in every cycle.
  - tick_rise = tick_in & ~tick_q, combinational.
  - Holding `tick_in` high for many cycles produces exactly one rise.
- Prescaler:
  - On tick_rise with run=1: if prescaler == TICKS_PER_SEC-1, clear it and assert sec_adv; otherwise increment it.
  - With run=0, rises are ignored and the prescaler holds.
- Latency: on sec_adv, sec_bcd updates at the same `clk` edge that samples the rise (one cycle after `tick_in` goes high). sec_pulse goes high at that same edge for one cycle.
- BCD arithmetic, per digit pair:
  - ones 9->0 with carry into tens.
  - Seconds 59->00 carries into minutes; minutes 59->00 carries into hours; hours 23->00 with no further carry.
  - The full ripple 23:59:59 -> 00:00:00 completes in a single cycle.
  - Digits never take values A..F.
- set_min:
  - min+1 with 59->00 wrap and no hour carry.
  - Seconds cleared to 00; prescaler cleared.
- set_hour: hour+1 with 23->00 wrap.
- set_min and set_hour in the same cycle: both apply.
- Any set pulse in a cycle suppresses that cycle's sec_adv and prescaler increment. sec_pulse stays 0; the tick is dropped, not deferred.
- A set pulse held high for N cycles gives N increments; debouncing and one-shot shaping are upstream.
- `reset` has priority over everything, including a tick or set in the same cycle.

Optional Feature:
- Macro: CLOCK_TWELVE_HOUR_EN.
- Defined:
  - hour_bcd sequences 12,01,02..11,12; reset value 8'h12.
  - An extra output port `pm` (1 bit, reset 0) toggles when hour moves 11->12, by carry or by set_hour.
  - Minute carry and set_hour follow the same 12-hour sequence.
- Undefined: 24-hour behaviour above; no `pm` port.

Decomposition:
- Shared package `clock_pkg`:
  - BCD limit constants: SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR24_MAX=8'h23, HOUR12_MAX=8'h12, HOUR12_MIN=8'h01.
  - A 4-bit bcd digit typedef.
- Sub-module: `bcd_mod_counter`, a two-digit BCD counter.
  - Inputs: inc, clr, max value, wrap value.
  - Output: carry on wrap.
  - Instantiated three times.

Test Plan:
1. Reset, TICKS_PER_SEC=1, tick_in toggling every 4 clk, run=1: after 60 rises, sec_bcd=00, min_bcd=01, sixty sec_pulse strobes, no BCD digit ever above 9.
2. Preload via set pulses to 23:59, then wait 59 ticks to reach 23:59:59; one rise -> 00:00:00 on the next edge, with sec_pulse=1 for exactly one cycle.
3. tick_in held high for 100 cycles after reset release -> no advance. Next 0->1 edge -> sec_bcd=01.
4. TICKS_PER_SEC=4, run=0 for 8 rises, then run=1 for 8 rises -> sec_bcd=02.
5. set_min coincident with a tick rise at 00:05:30 -> 00:06:00, no sec_pulse. set_min+set_hour together at 23:59 -> 00:00.
6. With CLOCK_TWELVE_HOUR_EN:
   - reset -> 12:00:00, pm=0.
   - set_hour x11 -> 11, pm=0; one more -> 12, pm=1.
   - 11:59:59 plus one tick -> 12:00:00 and pm toggles.

Source files
------------

// File: rtl/clock_time_counter_pkg.sv
// Shared types and BCD limit constants for the digital clock timekeeping path.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] SEC_MAX    = 8'h59;
  localparam logic [7:0] MIN_MAX    = 8'h59;
  localparam logic [7:0] HOUR24_MAX = 8'h23;
  localparam logic [7:0] HOUR12_MAX = 8'h12;
  localparam logic [7:0] HOUR12_MIN = 8'h01;

  // Packed two-digit BCD increment; the caller handles the wrap at its limit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    bcd_digit_t ones;
    bcd_digit_t tens;
    ones = v[3:0];
    tens = v[7:4];
    if (ones == 4'd9) begin
      ones = '0;
      tens = tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter with programmable limit and wrap value.
// carry is combinational so a full seconds->minutes->hours ripple lands on one edge.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  input  logic [7:0] max_val,
  input  logic [7:0] wrap_val,
  output logic [7:0] value,
  output logic       carry
);

  assign carry = inc && !clr && (value == max_val);

  // Count register: clear wins over increment, increment wraps at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= RESET_VAL;
    end else if (clr) begin
      value <= wrap_val;
    end else if (inc) begin
      value <= (value == max_val) ? wrap_val : bcd_inc(value);
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// Timekeeping core: edge-detects the divider's slow clock, prescales it to
// seconds and keeps hh:mm:ss in packed BCD with user set pulses.
// Optional 12-hour mode with pm indicator: define CLOCK_TWELVE_HOUR_EN.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned PRESC_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       run,
  input  logic       set_min,
  input  logic       set_hour,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
`ifdef CLOCK_TWELVE_HOUR_EN
  output logic       pm,
`endif
  output logic       sec_pulse
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

`ifdef CLOCK_TWELVE_HOUR_EN
  localparam logic [7:0] HOUR_MAX   = HOUR12_MAX;
  localparam logic [7:0] HOUR_WRAP  = HOUR12_MIN;
  localparam logic [7:0] HOUR_RESET = HOUR12_MAX;
`else
  localparam logic [7:0] HOUR_MAX   = HOUR24_MAX;
  localparam logic [7:0] HOUR_WRAP  = 8'h00;
  localparam logic [7:0] HOUR_RESET = 8'h00;
`endif

  logic               tick_q;
  logic               tick_rise;
  logic               set_any;
  logic [PRESC_W-1:0] presc;
  logic               sec_adv;
  logic               sec_carry;
  logic               min_carry;
  logic               min_inc;
  logic               hour_inc;
  logic               hour_carry_unused;

  assign tick_rise = tick_in & ~tick_q;
  assign set_any   = set_min | set_hour;
  assign sec_adv   = tick_rise & run & ~set_any & (presc == PRESC_LAST);

  // A set_min bumps minutes directly; its counter carry must not reach hours.
  assign min_inc  = sec_carry | set_min;
  assign hour_inc = (min_carry & ~set_min) | set_hour;

  // Tick edge detector; reset to 1 so a level already high at release is ignored.
  always_ff @(posedge clk) begin
    if (reset) tick_q <= 1'b1;
    else       tick_q <= tick_in;
  end

  // Prescaler: set pulses drop the tick; set_min also restarts the second.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (set_min) begin
      presc <= '0;
    end else if (!set_hour && tick_rise && run) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  // One-cycle strobe aligned with the seconds update.
  always_ff @(posedge clk) begin
    if (reset) sec_pulse <= 1'b0;
    else       sec_pulse <= sec_adv;
  end

  bcd_mod_counter #(.RESET_VAL(8'h00)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .inc      (sec_adv),
    .clr      (set_min),
    .max_val  (SEC_MAX),
    .wrap_val (8'h00),
    .value    (sec_bcd),
    .carry    (sec_carry)
  );

  bcd_mod_counter #(.RESET_VAL(8'h00)) u_min (
    .clk      (clk),
    .reset    (reset),
    .inc      (min_inc),
    .clr      (1'b0),
    .max_val  (MIN_MAX),
    .wrap_val (8'h00),
    .value    (min_bcd),
    .carry    (min_carry)
  );

  bcd_mod_counter #(.RESET_VAL(HOUR_RESET)) u_hour (
    .clk      (clk),
    .reset    (reset),
    .inc      (hour_inc),
    .clr      (1'b0),
    .max_val  (HOUR_MAX),
    .wrap_val (HOUR_WRAP),
    .value    (hour_bcd),
    .carry    (hour_carry_unused)
  );

`ifdef CLOCK_TWELVE_HOUR_EN
  // Meridiem flips whenever the hour steps 11 -> 12.
  always_ff @(posedge clk) begin
    if (reset)                            pm <= 1'b0;
    else if (hour_inc && hour_bcd == 8'h11) pm <= ~pm;
  end
`endif

endmodule
